// File: rtl/xadc_trig_capture.sv
// Triggered multi-channel XADC capture buffer: pre-trigger history, level/slope trigger, decimation, ping-pong banks.
// rd_data has 1-cycle latency; no backpressure: samples arriving outside a capture window are dropped.
module xadc_trig_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CH     = 2,
    parameter int PRETRIG    = 320,
    parameter int AUTO_TO    = 4096,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [CH_W-1:0]       s_ch,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  arm,
    input  logic [1:0]            mode,
    input  logic [CH_W-1:0]       trig_ch,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_slope,
    input  logic [7:0]            decim,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_valid,
    output logic                  busy,
    output logic                  forced,
    output logic [2:0]            state
);
    localparam int CW   = (ADDR_WIDTH > $clog2(AUTO_TO + 1)) ? ADDR_WIDTH : $clog2(AUTO_TO + 1);
    localparam int MA_W = 1 + CH_W + ADDR_WIDTH;
    localparam logic [CW-1:0]         PRE_N  = CW'(PRETRIG);
    localparam logic [CW-1:0]         POST_N = CW'(2**ADDR_WIDTH - PRETRIG - 1);
    localparam logic [CW-1:0]         AUTO_N = CW'(AUTO_TO);
    localparam logic [ADDR_WIDTH-1:0] PRE_A  = ADDR_WIDTH'(PRETRIG);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                st, st_n;
    logic [DATA_WIDTH-1:0] mem [0:(2**MA_W)-1];
    logic                  capturing, smp_ok, frame_end, kept, kept_end;
    logic                  trig_evt, hit, force_hit, go_done, restart;
    logic [DATA_WIDTH-1:0] tval, prev_val, cur_trig;
    logic                  prev_vld, wbank, cap_forced;
    logic [7:0]            dcnt;
    logic [ADDR_WIDTH-1:0] wptr, trig_ptr, disp_base, rd_ptr;
    logic [CW-1:0]         fcnt, fcnt_inc;
    logic [1:0]            mode_q;

    assign capturing = (st == S_PRE) || (st == S_ARMED) || (st == S_POST);
    assign smp_ok    = s_valid && (int'(s_ch) < NUM_CH) && capturing && !arm;
    assign frame_end = smp_ok && (int'(s_ch) == NUM_CH - 1);
    assign kept      = (dcnt == 8'd0);
    assign kept_end  = frame_end && kept;
    assign fcnt_inc  = fcnt + CW'(1);

    // The trigger-channel sample may arrive before or on the frame-closing sample.
    assign tval     = (s_ch == trig_ch) ? s_data : cur_trig;
    assign trig_evt = prev_vld && (trig_slope ? (prev_val > trig_level && tval <= trig_level)
                                              : (prev_val < trig_level && tval >= trig_level));

    always_comb begin
        st_n      = st;
        hit       = 1'b0;
        force_hit = 1'b0;
        case (st)
            S_IDLE: ;
            S_PRE:
                if (PRE_N == '0 || (kept_end && fcnt_inc == PRE_N)) st_n = S_ARMED;
            S_ARMED:
                if (kept_end) begin
                    if (trig_evt) begin
                        hit  = 1'b1;
                        st_n = S_POST;
                    end else if (mode_q == 2'd0 && fcnt_inc == AUTO_N) begin
                        force_hit = 1'b1;
                        st_n      = S_POST;
                    end
                end
            S_POST:
                if (POST_N == '0 || (kept_end && fcnt_inc == POST_N)) st_n = S_DONE;
            S_DONE:
                if (mode_q != 2'd2) st_n = S_PRE;
            default: st_n = S_IDLE;
        endcase
        if (arm) begin
            st_n      = S_PRE;
            hit       = 1'b0;
            force_hit = 1'b0;
        end
    end

    assign go_done = (st_n == S_DONE) && (st != S_DONE);
    assign restart = arm || (st == S_DONE && st_n == S_PRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            mode_q      <= 2'd0;
            fcnt        <= '0;
            dcnt        <= 8'd0;
            wptr        <= '0;
            prev_vld    <= 1'b0;
            prev_val    <= '0;
            cur_trig    <= '0;
            trig_ptr    <= '0;
            cap_forced  <= 1'b0;
            wbank       <= 1'b0;
            disp_base   <= '0;
            frame_valid <= 1'b0;
            forced      <= 1'b0;
        end else begin
            st <= st_n;
            // Mode is sampled only on transitions so a change lands at the next state boundary.
            if (arm || st_n != st) begin
                mode_q <= mode;
                fcnt   <= '0;
            end else if (kept_end) begin
                fcnt <= fcnt_inc;
            end
            if (restart) begin
                dcnt     <= 8'd0;
                prev_vld <= 1'b0;
            end else if (frame_end) begin
                dcnt <= (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
                if (kept) begin
                    prev_val <= tval;
                    prev_vld <= 1'b1;
                    wptr     <= wptr + 1'b1;
                end
            end
            if (smp_ok && kept && s_ch == trig_ch) cur_trig <= s_data;
            if (hit || force_hit) begin
                trig_ptr   <= wptr;
                cap_forced <= force_hit;
            end
            if (go_done) begin
                wbank       <= ~wbank;
                disp_base   <= trig_ptr - PRE_A;
                frame_valid <= 1'b1;
                forced      <= cap_forced;
            end
        end
    end

    // The display bank is always the bank not being written.
    always_ff @(posedge clk) begin
        if (smp_ok && kept) mem[{wbank, s_ch, wptr}] <= s_data;
    end

    assign rd_ptr = disp_base + rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (frame_valid && int'(rd_ch) < NUM_CH)
            rd_data <= mem[{~wbank, rd_ch, rd_ptr}];
        else
            rd_data <= '0;
    end

    assign busy  = (st != S_IDLE) && (st != S_DONE);
    assign state = st;
endmodule

// File: tb/tb_xadc_trig_capture.sv
// Bench for xadc_trig_capture: directed scenarios with random data, checked against a frame-level model.
// A second small instance covers decimation and out-of-range channel samples.
module tb_xadc_trig_capture;
    localparam int DEPTH = 1024;
    localparam int PT    = 320;
    localparam int ATO   = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, arm, trig_slope, frame_valid, busy, forced;
    logic [0:0]  s_ch, trig_ch, rd_ch;
    logic [11:0] s_data, trig_level, rd_data;
    logic [1:0]  mode;
    logic [7:0]  decim;
    logic [9:0]  rd_addr;
    logic [2:0]  state;

    logic        b_s_valid, b_arm, b_trig_slope, b_frame_valid, b_busy, b_forced;
    logic [1:0]  b_s_ch, b_trig_ch, b_rd_ch, b_mode;
    logic [11:0] b_s_data, b_trig_level, b_rd_data;
    logic [7:0]  b_decim;
    logic [2:0]  b_rd_addr, b_state;

    int checks = 0;
    int errors = 0;
    int fr0[$], fr1[$], k0[$], k1[$], kt[$];
    int exp0[DEPTH], exp1[DEPTH];
    int t, t3, n3;

    xadc_trig_capture dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data), .arm(arm),
        .mode(mode), .trig_ch(trig_ch), .trig_level(trig_level), .trig_slope(trig_slope),
        .decim(decim), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_valid(frame_valid), .busy(busy), .forced(forced), .state(state)
    );

    xadc_trig_capture #(.DATA_WIDTH(12), .ADDR_WIDTH(3), .NUM_CH(3), .PRETRIG(2), .AUTO_TO(8)) dut3 (
        .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ch(b_s_ch), .s_data(b_s_data), .arm(b_arm),
        .mode(b_mode), .trig_ch(b_trig_ch), .trig_level(b_trig_level), .trig_slope(b_trig_slope),
        .decim(b_decim), .rd_ch(b_rd_ch), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .frame_valid(b_frame_valid), .busy(b_busy), .forced(b_forced), .state(b_state)
    );

    always #5 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic gap;
        if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_frame(input int a, input int b);
        s_valid = 1'b1; s_ch = 1'b0; s_data = 12'(a); tick(); gap();
        s_valid = 1'b1; s_ch = 1'b1; s_data = 12'(b); tick();
        s_valid = 1'b0; gap();
    endtask

    task automatic do_arm(input int m);
        mode = 2'(m); arm = 1'b1; tick(); arm = 1'b0;
    endtask

    // Index of the kept frame that triggers, scanning only frames captured after the pre-trigger fill.
    function automatic int find_trig(input int m, input int sl, input int lv, output bit frc);
        frc = 1'b0;
        for (int i = PT; i < kt.size(); i++) begin
            if (i > 0 && (sl == 0 ? (kt[i-1] < lv && kt[i] >= lv) : (kt[i-1] > lv && kt[i] <= lv)))
                return i;
            if (m == 0 && i - PT + 1 == ATO) begin
                frc = 1'b1;
                return i;
            end
        end
        return -1;
    endfunction

    task automatic rd_chk(input int c, input int a, input int e, input string tag);
        rd_ch = 1'(c); rd_addr = 10'(a); tick();
        chk(tag, 32'(rd_data), e);
    endtask

    task automatic check_display(input string tag);
        int a;
        for (int n = 0; n < 10; n++) begin
            case (n)
                0: a = 0;
                1: a = PT - 1;
                2: a = PT;
                3: a = DEPTH - 1;
                default: a = $urandom_range(0, DEPTH - 1);
            endcase
            rd_chk(0, a, exp0[a], {tag, "_ch0"});
            rd_chk(1, a, exp1[a], {tag, "_ch1"});
        end
    endtask

    task automatic run(input int m, input int sl, input int lv, input int tc, input int dc,
                       input int post_stop, input string tag, output int tt);
        bit frc;
        int last, nraw;
        k0.delete(); k1.delete(); kt.delete();
        for (int j = 0; j < fr0.size(); j++)
            if (j % (dc + 1) == 0) begin
                k0.push_back(fr0[j]);
                k1.push_back(fr1[j]);
                kt.push_back(tc != 0 ? fr1[j] : fr0[j]);
            end
        tt = find_trig(m, sl, lv, frc);
        if (tt < 0) nraw = fr0.size();
        else begin
            last = (post_stop >= 0) ? tt + post_stop : tt + DEPTH - PT - 1;
            nraw = last * (dc + 1) + 1;
        end
        trig_slope = 1'(sl); trig_level = 12'(lv); trig_ch = 1'(tc); decim = 8'(dc);
        do_arm(m);
        for (int j = 0; j < nraw; j++) send_frame(fr0[j], fr1[j]);
        if (post_stop >= 0) return;
        tick(); tick();
        if (tt < 0) begin
            chk({tag, "_armed_state"}, 32'(state), 2);
            chk({tag, "_armed_busy"}, 32'(busy), 1);
            return;
        end
        chk({tag, "_end_state"}, 32'(state), (m == 2) ? 4 : 1);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 1);
        chk({tag, "_forced"}, 32'(forced), 32'(frc));
        for (int k = 0; k < DEPTH; k++) begin
            exp0[k] = k0[tt - PT + k];
            exp1[k] = k1[tt - PT + k];
        end
        check_display(tag);
    endtask

    task automatic fill(input int n, input int kind);
        fr0.delete(); fr1.delete();
        for (int j = 0; j < n; j++) begin
            case (kind)
                0: fr0.push_back((j * 8) % 4096);
                1: fr0.push_back(j < 400 ? 3000 : 1000);
                2: fr0.push_back(2000);
                3: fr0.push_back(100);
                4: fr0.push_back((j * 8 + 4) % 4096);
                5: fr0.push_back(500);
                default: fr0.push_back($urandom_range(0, 4095));
            endcase
            fr1.push_back($urandom_range(0, 4095));
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0; arm = 1'b0; mode = 2'd1;
        trig_ch = '0; trig_level = '0; trig_slope = 1'b0; decim = '0; rd_ch = '0; rd_addr = '0;
        b_s_valid = 1'b0; b_s_ch = '0; b_s_data = '0; b_arm = 1'b0; b_mode = 2'd1;
        b_trig_ch = '0; b_trig_level = '0; b_trig_slope = 1'b0; b_decim = '0; b_rd_ch = '0; b_rd_addr = '0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_forced", 32'(forced), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        tick();
        chk("idle_state", 32'(state), 0);

        // Rising ramp through 2048 in normal mode.
        fill(1500, 0);
        run(1, 0, 2048, 0, 0, -1, "ramp", t);
        rd_chk(0, 320, 2048, "ramp_at_trig");
        rd_chk(0, 319, 2040, "ramp_before_trig");

        // Falling step, then a constant sitting exactly at the level.
        fill(1120, 1);
        run(1, 1, 2000, 0, 0, -1, "fall", t);
        fill(600, 2);
        run(1, 1, 2000, 0, 0, -1, "flat", t);

        // Auto mode on a constant input must force a trigger.
        fill(5120, 3);
        run(0, 0, 2048, 0, 0, -1, "auto", t);

        // Single mode holds its frame against further samples.
        fill(1400, 0);
        run(2, 0, 1000, 0, 0, -1, "single", t);
        for (int j = 0; j < 50; j++) send_frame($urandom_range(0, 4095), $urandom_range(0, 4095));
        tick();
        chk("single_hold_state", 32'(state), 4);
        check_display("single_hold");

        // Re-arm while in POST: capture restarts, display unchanged.
        fill(1400, 4);
        run(1, 0, 1000, 0, 0, 5, "post_arm", t);
        chk("post_state_before_arm", 32'(state), 3);
        do_arm(1);
        chk("post_arm_state", 32'(state), 1);
        chk("post_arm_frame_valid", 32'(frame_valid), 1);
        check_display("post_arm");

        // Random data, random slope/level/trigger channel/decimation.
        for (int r = 0; r < 2; r++) begin
            fill(4000, 9);
            run(1, $urandom_range(0, 1), $urandom_range(1000, 3000), $urandom_range(0, 1),
                $urandom_range(0, 1), -1, "rand", t);
        end

        // Reset in the middle of ARMED.
        fill(330, 5);
        run(1, 0, 2048, 0, 0, -1, "pre_rst", t);
        rst = 1'b1;
        tick();
        chk("midrst_state", 32'(state), 0);
        chk("midrst_frame_valid", 32'(frame_valid), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        chk("midrst_forced", 32'(forced), 0);
        rst = 1'b0;
        tick();

        // Small instance: decim=3, ramp per frame, stray channel-3 samples inside each frame.
        t3 = -1;
        for (int i = 2; i < 64 && t3 < 0; i++)
            if (4 * (i - 1) < 30 && 4 * i >= 30) t3 = i;
        n3 = (t3 + 8 - 2 - 1) * 4 + 1;
        b_trig_level = 12'd30; b_trig_slope = 1'b0; b_trig_ch = 2'd0; b_decim = 8'd3; b_mode = 2'd1;
        b_arm = 1'b1; tick(); b_arm = 1'b0;
        for (int j = 0; j < n3; j++)
            for (int c = 0; c < 3; c++) begin
                if (c == 1) begin
                    b_s_valid = 1'b1; b_s_ch = 2'd3; b_s_data = 12'hfa0; tick();
                end
                b_s_valid = 1'b1; b_s_ch = 2'(c); b_s_data = 12'(j + 100 * c); tick();
            end
        b_s_valid = 1'b0;
        tick(); tick();
        chk("dec_state", 32'(b_state), 1);
        chk("dec_frame_valid", 32'(b_frame_valid), 1);
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 3; c++) begin
                b_rd_ch = 2'(c); b_rd_addr = 3'(k); tick();
                chk("dec_read", 32'(b_rd_data), 4 * (t3 - 2 + k) + 100 * c);
            end
        b_rd_ch = 2'd3; b_rd_addr = 3'd0; tick();
        chk("dec_bad_ch_read", 32'(b_rd_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
